// File: rtl/speaker_i2s_tx.sv
// speaker_i2s_tx: stereo 16-bit I2S transmitter for the CS4344 Pmod DAC.
// A free-running 9-bit frame counter (512 clk per frame) generates MCLK
// (clk/4), SCK (clk/16) and LRCK (clk/512) directly from counter bits. One
// L/R pair is latched once per frame and serialized MSB first with the I2S
// one-bit delay.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          asynchronous active-high reset
//   audio_left   left sample, two's complement
//   audio_right  right sample, two's complement
//   audio_mclk   DAC master clock, clk/4
//   audio_lrck   word select, 0 = left, 1 = right
//   audio_sck    serial bit clock, clk/16
//   audio_sdin   serial data, registered, changes on SCK falling edges
//   frame_start  one-clk pulse on the cycle the new L/R pair is latched
module speaker_i2s_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin,
    output logic        frame_start
);

    localparam int unsigned CNT_W    = 9;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SLOT_W   = 4;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] right_q;
    logic                prev_lsb;
    logic                prev_lsb_nxt;
    logic                sdin_q;
    logic                sdin_nxt;
    logic                last;
    logic [SLOT_W-1:0]   slot_nxt;
    logic [SLOT_W-1:0]   bit_idx;
    logic                ch_nxt;

    // Frame counter wraps naturally at 512.
    assign cnt_nxt = cnt + CNT_W'(1);
    assign last    = (cnt == {CNT_W{1'b1}});

    // The delayed-LSB bit as it will be after this edge; slot 0 of the new
    // frame must already carry the outgoing right word's LSB.
    assign prev_lsb_nxt = last ? right_q[0] : prev_lsb;

    // Serial bit for the slot the counter is about to enter.
    always_comb begin
        slot_nxt = cnt_nxt[7:4];
        ch_nxt   = cnt_nxt[8];
        bit_idx  = SLOT_W'(0) - slot_nxt;  // 16 - s for s = 1..15
        sdin_nxt = sdin_q;
        if (cnt_nxt[3:0] == SLOT_W'(0)) begin
            if (slot_nxt == SLOT_W'(0)) begin
                sdin_nxt = ch_nxt ? left_q[0] : prev_lsb_nxt;
            end else begin
                sdin_nxt = ch_nxt ? right_q[bit_idx] : left_q[bit_idx];
            end
        end
    end

    // Counter, sample shadow registers and serial data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            left_q   <= '0;
            right_q  <= '0;
            prev_lsb <= 1'b0;
            sdin_q   <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            sdin_q   <= sdin_nxt;
            prev_lsb <= prev_lsb_nxt;
            if (last) begin
                left_q  <= audio_left;
                right_q <= audio_right;
            end
        end
    end

    // DAC clocks come straight from counter flops, so they are glitch-free.
    assign audio_mclk  = cnt[1];
    assign audio_sck   = cnt[3];
    assign audio_lrck  = cnt[8];
    assign audio_sdin  = sdin_q;
    assign frame_start = last;

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// tb_speaker_i2s_tx: directed bench for speaker_i2s_tx. Expected L/R words
// are queued when a pair is presented at a latch point and compared against
// the words decoded from audio_sdin one frame later. A reference frame
// counter checks clock outputs, frame_start and sdin change points.
module tb_speaker_i2s_tx;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
    logic        frame_start;

    int compared = 0;
    int mismatched = 0;

    pair_t       exp_q[$];
    logic [8:0]  mcnt;
    logic [15:0] sr = '0;
    logic [15:0] left_word = '0;
    logic        left_valid = 1'b0;
    logic        sdin_prev = 1'b0;

    speaker_i2s_tx dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .audio_sdin  (audio_sdin),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame position: 0 on the first clk after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= '0;
        else     mcnt <= mcnt + 9'd1;
    end

    // Clock ratios, frame_start position and sdin change points.
    always @(negedge clk) begin
        if (!rst) begin
            check("mclk", 32'(audio_mclk), 32'(mcnt[1]));
            check("sck", 32'(audio_sck), 32'(mcnt[3]));
            check("lrck", 32'(audio_lrck), 32'(mcnt[8]));
            check("frame_start", 32'(frame_start), 32'(mcnt == 9'd511));
            if (audio_sdin !== sdin_prev)
                check("sdin_change_pos", 32'(mcnt[3:0]), 32'd0);
        end
        sdin_prev = audio_sdin;
    end

    // Decode sdin on each SCK rise and score completed L/R pairs.
    always @(negedge clk) begin
        pair_t e;
        if (rst) begin
            left_valid = 1'b0;
        end else if (mcnt[3:0] == 4'd8) begin
            sr = {sr[14:0], audio_sdin};
            if (mcnt[8] && mcnt[7:4] == 4'd0) begin
                left_word  = sr;
                left_valid = 1'b1;
            end else if (!mcnt[8] && mcnt[7:4] == 4'd0 && left_valid) begin
                check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("left_word", 32'(left_word), 32'(e.l));
                    check("right_word", 32'(sr), 32'(e.r));
                end
            end
        end
    end

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(mcnt) != v && n < 1024);
        check("wait_cnt", 32'(mcnt), 32'(v));
    endtask

    // Run n latch points; present (l,r) at each latch and optionally at cnt==mid.
    task automatic run(input int n, input logic [15:0] l, input logic [15:0] r, input int mid);
        int seen = 0;
        int fs = 0;
        int steps = 0;
        while (seen < n && steps < n * 512 + 512) begin
            @(negedge clk);
            steps++;
            if (frame_start) fs++;
            if (int'(mcnt) == mid) begin
                audio_left  = l;
                audio_right = r;
            end
            if (mcnt == 9'd511) begin
                audio_left  = l;
                audio_right = r;
                exp_q.push_back({l, r});
                seen++;
            end
        end
        check("frames_run", 32'(seen), 32'(n));
        check("frame_start_pulses", 32'(fs), 32'(n));
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_mclk", 32'(audio_mclk), 32'd0);
        check("rst_sck", 32'(audio_sck), 32'd0);
        check("rst_lrck", 32'(audio_lrck), 32'd0);
        check("rst_sdin", 32'(audio_sdin), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        exp_q.push_back('0);

        // First edges after release.
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (k == 1)   check("mclk_low_k1", 32'(audio_mclk), 32'd0);
            if (k == 2)   check("mclk_rise_k2", 32'(audio_mclk), 32'd1);
            if (k == 7)   check("sck_low_k7", 32'(audio_sck), 32'd0);
            if (k == 8)   check("sck_rise_k8", 32'(audio_sck), 32'd1);
            if (k == 255) check("lrck_low_k255", 32'(audio_lrck), 32'd0);
            if (k == 256) check("lrck_rise_k256", 32'(audio_lrck), 32'd1);
        end

        // Constant data and free-run ratio.
        run(1, 16'hA5C3, 16'h3C5A, -1);
        run(4, 16'hA5C3, 16'h3C5A, -1);

        // Tear-free latching: mid-frame input change is ignored until next latch.
        run(1, 16'h5000, 16'hB000, -1);
        run(1, 16'h1234, 16'h4321, 100);
        run(1, 16'h1234, 16'h4321, -1);

        // Delayed LSB: L=R=1 frame, followed by an all-zero frame.
        run(1, 16'h0001, 16'h0001, -1);
        wait_cnt(264);
        check("right_slot0_is_left_lsb", 32'(audio_sdin), 32'd1);
        run(1, 16'h0000, 16'h0000, -1);
        wait_cnt(8);
        check("left_slot0_is_prev_right_lsb", 32'(audio_sdin), 32'd1);
        run(1, 16'h0000, 16'h0000, -1);

        // Random samples.
        for (int i = 0; i < 10; i++)
            run(1, 16'($urandom), 16'($urandom), -1);

        // Mid-frame reset while clocks and sdin are all high.
        run(1, 16'hFFFF, 16'hFFFF, -1);
        wait_cnt(266);
        check("pre_rst_sdin", 32'(audio_sdin), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_mclk", 32'(audio_mclk), 32'd0);
        check("midrst_sck", 32'(audio_sck), 32'd0);
        check("midrst_lrck", 32'(audio_lrck), 32'd0);
        check("midrst_sdin", 32'(audio_sdin), 32'd0);
        check("midrst_frame_start", 32'(frame_start), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('0);
        run(2, 16'h1111, 16'h2222, -1);
        wait_cnt(20);
        check("queue_left", 32'(exp_q.size()), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
